// File: rtl/sysid_check.sv
// Boot-time sysid checker: reads ID (addr 0) and timestamp (addr 1), compares them, counts failed checks.
// done rises 4+2*RD_LAT edges after reset release and 3+2*RD_LAT edges after a start sampled in DONE; no stalls.
module sysid_check #(
   parameter logic [31:0] EXP_ID = 32'd10,
   parameter logic [31:0] EXP_TS = 32'd1461311182,
   parameter int unsigned RD_LAT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        done,
   output logic        busy,
   output logic [7:0]  err_count
);

   typedef enum logic [2:0] {
      START, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CMP, DONE
   } state_t;

   localparam int unsigned LAT_M1 = (RD_LAT == 0) ? 0 : RD_LAT - 1;

   state_t     state, state_nxt;
   logic [2:0] lat_cnt, lat_cnt_nxt;
   logic       addr_q;
   logic       cap_id, cap_ts, cmp_en, clr_res;
   logic       id_match, ts_match;

   assign id_match = (id_value == EXP_ID);
   assign ts_match = (ts_value == EXP_TS);
   assign busy     = (state != DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= START;
         lat_cnt   <= 3'd0;
         addr_q    <= 1'b0;
         id_value  <= 32'd0;
         ts_value  <= 32'd0;
         id_ok     <= 1'b0;
         ts_ok     <= 1'b0;
         done      <= 1'b0;
         err_count <= 8'd0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
         addr_q  <= avm_address;
         if (cap_id) id_value <= avm_readdata;
         if (cap_ts) ts_value <= avm_readdata;
         if (clr_res) begin
            done  <= 1'b0;
            id_ok <= 1'b0;
            ts_ok <= 1'b0;
         end
         if (cmp_en) begin
            id_ok <= id_match;
            ts_ok <= ts_match;
            done  <= 1'b1;
            // saturate rather than wrap so a long-failing board never reads back as healthy
            if (!(id_match && ts_match) && (err_count != 8'hFF))
               err_count <= err_count + 8'd1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      avm_read    = 1'b0;
      avm_address = addr_q;
      cap_id      = 1'b0;
      cap_ts      = 1'b0;
      cmp_en      = 1'b0;
      clr_res     = 1'b0;
      case (state)
         START: state_nxt = RD_ID;
         RD_ID: begin
            avm_read    = 1'b1;
            avm_address = 1'b0;
            if (RD_LAT == 0) begin
               cap_id    = 1'b1;
               state_nxt = RD_TS;
            end else begin
               lat_cnt_nxt = LAT_M1[2:0];
               state_nxt   = WAIT_ID;
            end
         end
         WAIT_ID: begin
            if (lat_cnt == 3'd0) begin
               cap_id    = 1'b1;
               state_nxt = RD_TS;
            end else begin
               lat_cnt_nxt = lat_cnt - 3'd1;
            end
         end
         RD_TS: begin
            avm_read    = 1'b1;
            avm_address = 1'b1;
            if (RD_LAT == 0) begin
               cap_ts    = 1'b1;
               state_nxt = CMP;
            end else begin
               lat_cnt_nxt = LAT_M1[2:0];
               state_nxt   = WAIT_TS;
            end
         end
         WAIT_TS: begin
            if (lat_cnt == 3'd0) begin
               cap_ts    = 1'b1;
               state_nxt = CMP;
            end else begin
               lat_cnt_nxt = lat_cnt - 3'd1;
            end
         end
         CMP: begin
            cmp_en    = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            if (start) begin
               clr_res   = 1'b1;
               state_nxt = RD_ID;
            end
         end
         default: state_nxt = START;
      endcase
   end

endmodule
